// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the legal WIDTH range.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fa_slice.sv
// Combinational one-bit full adder.
// Shared by every bit position of the serial datapath.
module fa_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first,
// with valid/ready handshakes on operands and result.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fs;
  logic             fc;

  fa_slice u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fs),
    .cout (fc)
  );

  always_comb begin
    sum_nx = sum >> 1;
    sum_nx[WIDTH-1] = fs;
  end

  assign start_ready = (state == IDLE);

  // carry entering the MSB is the register value on the last run edge,
  // so overflow needs no separate latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{sub}};
            carry <= sub | cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= sum_nx;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fc;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout      <= fc;
            ovf       <= fc ^ carry;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Expected values are hand-computed constants.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sv, sr, cin, sub, cout, ovf, rv, rr;
  logic [7:0] a, b, sum;
  logic       sv1, sr1, cin1, sub1, cout1, ovf1, rv1, rr1;
  logic [0:0] a1, b1, sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .start_valid(sv), .start_ready(sr),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .sum(sum), .cout(cout), .ovf(ovf),
    .res_valid(rv), .res_ready(rr)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .start_valid(sv1), .start_ready(sr1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .sum(sum1), .cout(cout1), .ovf(ovf1),
    .res_valid(rv1), .res_ready(rr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept an operand pair on the next edge, return edges until res_valid
  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tc, input logic ts, output int n);
    a = ta; b = tb_; cin = tc; sub = ts; sv = 1'b1;
    tick();
    sv = 1'b0;
    n = 0;
    while (rv !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] ta,
                     input logic [7:0] tb_, input logic tc,
                     input logic ts, input logic [7:0] es,
                     input logic ec, input logic eo);
    int n;
    issue8(ta, tb_, tc, ts, n);
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    rr = 1'b1;
    tick();
    rr = 1'b0;
    chk({tag, "_idle"}, {sr, rv}, 2'b10);
  endtask

  logic [1:0] fa_tab [8];
  logic [2:0] v;
  int         n;

  initial begin
    fa_tab = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    rst = 1'b1;
    sv = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; rr = 1'b0;
    sv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; rr1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_out8", {sum, cout, ovf, rv, sr}, {8'h00, 4'b0001});
    chk("rst_out1", {sum1, cout1, ovf1, rv1, sr1}, 5'b00001);

    op8("add", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
    op8("wrap", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    op8("sub1", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    op8("sub2", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; sv1 = 1'b1;
      tick();
      sv1 = 1'b0;
      n = 0;
      while (rv1 !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("w1_lat%0d", i), n, 1);
      chk($sformatf("w1_fa%0d", i), {cout1, sum1}, fa_tab[i]);
      rr1 = 1'b1;
      tick();
      rr1 = 1'b0;
      chk($sformatf("w1_idle%0d", i), {sr1, rv1}, 2'b10);
    end

    issue8(8'h5A, 8'h33, 1'b0, 1'b0, n);
    chk("bp_lat", n, 8);
    for (int i = 0; i < 20; i++) begin
      sv = i[0];
      a = 8'(i * 7);
      b = 8'(i * 13);
      tick();
      chk($sformatf("bp_hold%0d", i),
          {rv, sr, sum, cout, ovf}, {2'b10, 8'h8D, 2'b01});
    end
    sv = 1'b1;
    rr = 1'b1;
    tick();
    sv = 1'b0;
    rr = 1'b0;
    chk("bp_release", {sr, rv}, 2'b10);
    tick();
    chk("bp_nobypass", {sr, rv}, 2'b10);

    a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0; sv = 1'b1;
    tick();
    sv = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_state", {sr, rv}, 2'b10);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rv !== 1'b0) n++;
    end
    chk("abort_noresult", n, 0);

    op8("post", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder/subtractor built from one full-adder slice and a carry flip-flop. It accepts an operand pair through a valid/ready handshake and processes one bit per clock, LSB first. It presents sum, carry-out and signed overflow through a second valid/ready handshake. This is the sequential hardware counterpart of the combinational full-adder cell and its stimulus benches, for area-constrained datapaths in the adder library.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  operand pair offered
- start_ready  out  1  block can accept operands; high only in IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in for add mode; ignored when sub=1
- sub  in  1  0: a+b+cin; 1: a-b (computed as a+~b+1)
- sum  out  WIDTH  result; meaningful only while res_valid=1
- cout  out  1  final carry; in sub mode 1 means no borrow
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result

## Operation
- States are IDLE, RUN and DONE. Reset puts the block in IDLE with sum=0, cout=0, ovf=0, res_valid=0, bit counter=0. start_ready=1 follows from IDLE.
- IDLE: on start_valid=1 at an edge, capture a into shift register A and (b XOR {WIDTH{sub}}) into shift register B. Set carry = sub ? 1 : cin, clear the counter, go to RUN. With no start_valid, stay in IDLE.
- RUN: each edge, the slice adds A[0], B[0] and carry.
  - Shift the sum bit into the MSB of the sum register, shifting right.
  - Shift A and B right and update carry.
  - When the counter reaches WIDTH-2, latch the current carry as carry-into-MSB.
  - On the edge that processes bit WIDTH-1, set cout=carry-out and ovf=carry-out XOR carry-into-MSB, then go to DONE.
  - WIDTH=1: carry-into-MSB is the initial carry.
- DONE: res_valid=1. sum, cout and ovf hold stable. Go to IDLE on an edge with res_ready=1.
- Inputs a, b, cin, sub and start_valid are ignored outside IDLE. res_ready is ignored outside DONE.
- sum contents during RUN are partial and must not be used.
- Arithmetic is modulo 2^WIDTH. The carry beyond bit WIDTH-1 appears only on cout.

## Timing
- Operand accept edge = E.
- Bit i is processed at edge E+1+i.
- res_valid is high in the cycle after edge E+WIDTH. Latency is WIDTH cycles from accept.
- Minimum issue period is WIDTH+2 edges: accept, WIDTH run edges, then one DONE edge with res_ready=1. start_ready is high again in the cycle after the DONE handshake.
- There is no bypass. start_valid during DONE is not accepted even when res_ready=1 in the same cycle.
- Backpressure: DONE holds indefinitely while res_ready=0, with all outputs constant.
- rst has priority over every transition. Reset during RUN or DONE aborts the operation: the next cycle is IDLE with res_valid=0 and no result emitted.
- All outputs are registered, except start_ready, which decodes state.

## Structure
- Shared package adder_pkg holds the state enum (IDLE, RUN, DONE) and the WIDTH range-check constant.
- One sub-module: fa_slice, a combinational full adder (a, b, cin -> sum, cout) instantiated once. The FSM, counter and shift registers live in serial_adder.
- The counter width is $clog2(WIDTH) with a minimum of 1 bit.

## Test plan
- Add, WIDTH=8: a=8'h5A, b=8'h33, cin=0, sub=0 -> sum=8'h8D, cout=0, ovf=1. res_valid appears exactly 8 cycles after accept.
- Carry wrap, WIDTH=8: a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0.
- Subtract, WIDTH=8: a=8'h10, b=8'h20, sub=1, cin=1 (must be ignored) -> sum=8'hF0, cout=0, ovf=0. Then a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
- WIDTH=1 instance, all 8 {a,b,cin} values 0..7 in order with sub=0 -> {cout,sum} matches the full-adder truth table (0,1,1,2,1,2,2,3). Latency is 1 cycle.
- Backpressure: hold res_ready=0 for 20 cycles in DONE while toggling start_valid -> res_valid=1, start_ready=0, and sum, cout, ovf unchanged. res_ready=1 -> IDLE on the next edge.
- Reset on the 4th RUN edge -> next cycle IDLE with res_valid=0 and start_ready=1, and no result emitted. A following add of 8'h01+8'h01 -> sum=8'h02, cout=0.
